// File: rtl/truth_table_driver.sv
`default_nettype none
// ============================================================================
// Module   : truth_table_driver
// Brief    : Sweeps all 16 switch patterns into a combinational AND/OR DUT,
//            captures its 1-bit result per pattern and grades it against
//            (p[0]&p[1]) | (p[2]&p[3]). Optional macro STOP_ON_MISMATCH_EN
//            halts the sweep on the first failing pattern.
// Revision : 1.0 - initial release
// ============================================================================
module truth_table_driver #(
  parameter int HOLD_CYCLES = 4,
  parameter int PAT_W       = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    start,
  output logic [PAT_W-1:0]        tt_in,
  input  logic                    dut_out,
  output logic [(1<<PAT_W)-1:0]   table_q,
  output logic                    busy,
  output logic                    done,
  output logic                    mismatch,
  output logic [PAT_W:0]          err_count
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_drive  = 2'd1;
  localparam logic [1:0] c_sample = 2'd2;
  localparam logic [1:0] c_done   = 2'd3;

  localparam logic [15:0] c_golden    = 16'hF888;
  localparam logic [7:0]  c_hold_last = 8'(HOLD_CYCLES - 1);

  logic [1:0]              r_state;
  logic [7:0]              r_hold;
  logic [PAT_W-1:0]        r_pat;
  logic [PAT_W-1:0]        r_tt;
  logic [(1<<PAT_W)-1:0]   r_table;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_mismatch;
  logic [PAT_W:0]          r_err;

  logic                    w_golden;
  logic                    w_miss;
  logic                    w_last;
  logic                    w_halt;

  assign w_golden = c_golden[r_pat];
  assign w_miss   = (dut_out != w_golden);
  assign w_last   = (r_pat == '1);

`ifdef STOP_ON_MISMATCH_EN
  // Freeze on the first bad capture so the board shows the offending pattern.
  assign w_halt = w_last | w_miss;
`else
  assign w_halt = w_last;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state    <= c_idle;
      r_hold     <= '0;
      r_pat      <= '0;
      r_tt       <= '0;
      r_table    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
      r_err      <= '0;
    end else begin
      case (r_state)
        c_idle, c_done: begin
          if (r_state == c_idle) begin
            r_tt <= '0;
          end
          if (start) begin
            r_state    <= c_drive;
            r_hold     <= '0;
            r_pat      <= '0;
            r_tt       <= '0;
            r_table    <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
            r_err      <= '0;
          end
        end

        c_drive: begin
          r_tt   <= r_pat;
          r_hold <= r_hold + 8'd1;
          if (r_hold == c_hold_last) begin
            r_state <= c_sample;
          end
        end

        c_sample: begin
          r_table[r_pat] <= dut_out;
          if (w_miss) begin
            r_mismatch <= 1'b1;
            r_err      <= r_err + (PAT_W+1)'(1);
          end
          if (w_halt) begin
            r_state <= c_done;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= c_drive;
            r_pat   <= r_pat + PAT_W'(1);
            r_tt    <= r_pat + PAT_W'(1);
            r_hold  <= '0;
          end
        end

        default: begin
          r_state <= c_idle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign tt_in     = r_tt;
  assign table_q   = r_table;
  assign busy      = r_busy;
  assign done      = r_done;
  assign mismatch  = r_mismatch;
  assign err_count = r_err;

endmodule
`default_nettype wire
